mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `memory` block between the instruction-fetch stage and the data-memory stage of the pipeline. It latches one request at a time and holds the memory address, data and strobes stable for a fixed `LATENCY` cycles. It then returns read data with a one-cycle acknowledge pulse. When both ports are waiting, grants alternate round-robin so that neither stage starves.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-ported memory between the instruction-fetch
//             port (read only) and the data port (read/write). One request is
//             latched at a time. Address, data and strobes are held for
//             LATENCY cycles, then a one-cycle ack is returned with the
//             registered read data. Ties alternate round-robin.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             i_req/i_addr           - instruction read request and address
//             i_rdata/i_ack          - instruction read result and done pulse
//             d_req/d_we/d_addr/
//             d_wdata                - data request, write enable, address, data
//             d_rdata/d_ack          - data read result and done pulse
//             mem_addr/mem_wdata/
//             mem_read/mem_write     - registered memory request side
//             mem_rdata              - memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic [31:0]      i_addr,
   output logic [WIDTH-1:0] i_rdata,
   output logic             i_ack,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [31:0]      d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ack,
   output logic [31:0]      mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             mem_read,
   output logic             mem_write
);

   localparam int CW = $clog2(LATENCY) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_last;   // last granted port: 0 = I, 1 = D
   logic            r_we;     // latched write enable of the access in flight

   logic            w_i_elig;
   logic            w_d_elig;
   logic            w_grant_d;
   logic            w_grant_i;

   // A port whose ack is high this cycle is still holding the request it was
   // just served for, so it must not be granted again on that edge.
   assign w_i_elig  = i_req & ~i_ack;
   assign w_d_elig  = d_req & ~d_ack;
   assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last);
   assign w_grant_i = w_i_elig & ~w_grant_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_last    <= 1'b0;
         r_we      <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  r_we      <= d_we;
                  mem_write <= d_we;
                  mem_read  <= ~d_we;
                  r_cnt     <= CW'(LATENCY - 1);
                  r_last    <= 1'b1;
                  r_state   <= S_BUSY_D;
               end else if (w_grant_i) begin
                  mem_addr  <= i_addr;
                  mem_wdata <= d_wdata;
                  r_we      <= 1'b0;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  r_cnt     <= CW'(LATENCY - 1);
                  r_last    <= 1'b0;
                  r_state   <= S_BUSY_I;
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // Final strobe cycle: memory data is valid at this edge.
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  r_state   <= S_IDLE;
                  if (r_state == S_BUSY_I) begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end else begin
                     if (!r_we) begin
                        d_rdata <= mem_rdata;
                     end
                     d_ack <= 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter. Instance A uses
//             LATENCY=4, instance B uses LATENCY=1; each has its own small
//             word-addressed memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_init;

   // Instance A (LATENCY = 4)
   logic        a_i_req, a_i_ack, a_d_req, a_d_we, a_d_ack, a_mem_read, a_mem_write;
   logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   // Instance B (LATENCY = 1)
   logic        b_i_req, b_i_ack, b_d_req, b_d_we, b_d_ack, b_mem_read, b_mem_write;
   logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WIDTH(32), .LATENCY(4)) u_dut_a (
      .clk(clk), .reset(reset),
      .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_rdata(a_d_rdata), .d_ack(a_d_ack),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
      .mem_read(a_mem_read), .mem_write(a_mem_write)
   );

   mem_arbiter #(.WIDTH(32), .LATENCY(1)) u_dut_b (
      .clk(clk), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
      .mem_read(b_mem_read), .mem_write(b_mem_write)
   );

   // Word 2 (byte 0x08) holds 0x11111111; every other word n holds 0xC0DE000n.
   function automatic logic [31:0] init_word(input int i);
      return (i == 2) ? 32'h1111_1111 : (32'hC0DE_0000 | 32'(i));
   endfunction

   assign a_mem_rdata = mem_a[a_mem_addr[5:2]];
   assign b_mem_rdata = mem_b[b_mem_addr[5:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] <= init_word(i);
            mem_b[i] <= init_word(i);
         end
      end else begin
         if (a_mem_write) mem_a[a_mem_addr[5:2]] <= a_mem_wdata;
         if (b_mem_write) mem_b[b_mem_addr[5:2]] <= b_mem_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Drives one access on instance A and waits (bounded) for its ack.
   // lat = cycle index of the ack after the drive (-1 on timeout),
   // nstrobe = cycles with a strobe high, bus_ok = address/data/strobe sane.
   task automatic access_a(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat,
                           output int nstrobe, output bit bus_ok);
      lat = -1; nstrobe = 0; bus_ok = 1'b1;
      if (is_d) begin
         a_d_we = we; a_d_addr = addr; a_d_wdata = wdata; a_d_req = 1'b1;
      end else begin
         a_i_addr = addr; a_i_req = 1'b1;
      end
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (a_mem_read || a_mem_write) begin
            nstrobe++;
            if (a_mem_addr !== addr || (a_mem_read && a_mem_write) ||
                a_mem_write !== we || (we && a_mem_wdata !== wdata))
               bus_ok = 1'b0;
         end
         if ((is_d ? a_d_ack : a_i_ack) === 1'b1) begin
            lat = c;
            break;
         end
      end
      a_d_req = 1'b0;
      a_i_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_vec++; if ({a_i_ack, a_d_ack, a_mem_read, a_mem_write} !== 4'b0) begin
         n_fail++; $display("FAIL reset_strobes_a: got %b, expected 0000", {a_i_ack, a_d_ack, a_mem_read, a_mem_write}); end
      n_vec++; if ({a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin
         n_fail++; $display("FAIL reset_data_a: got %h, expected 0", {a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata}); end
      n_vec++; if ({b_i_ack, b_d_ack, b_mem_read, b_mem_write} !== 4'b0) begin
         n_fail++; $display("FAIL reset_strobes_b: got %b, expected 0000", {b_i_ack, b_d_ack, b_mem_read, b_mem_write}); end
      reset = 1'b0;
   endtask

   task automatic test_lone_read();
      logic exp_rd, exp_ack;
      a_i_addr = 32'h08;
      a_i_req  = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         exp_rd  = (c <= 4);
         exp_ack = (c == 5);
         n_vec++; if (a_mem_read !== exp_rd || a_mem_write !== 1'b0) begin
            n_fail++; $display("FAIL lone_strobe c%0d: got rd=%b wr=%b, expected rd=%b wr=0", c, a_mem_read, a_mem_write, exp_rd); end
         if (exp_rd) begin
            n_vec++; if (a_mem_addr !== 32'h08) begin
               n_fail++; $display("FAIL lone_addr c%0d: got %h, expected 00000008", c, a_mem_addr); end
         end
         n_vec++; if (a_i_ack !== exp_ack || a_d_ack !== 1'b0) begin
            n_fail++; $display("FAIL lone_ack c%0d: got i=%b d=%b, expected i=%b d=0", c, a_i_ack, a_d_ack, exp_ack); end
         if (a_i_ack === 1'b1) a_i_req = 1'b0;
      end
      a_i_req = 1'b0;
      n_vec++; if (a_i_rdata !== 32'h1111_1111) begin
         n_fail++; $display("FAIL lone_rdata: got %h, expected 11111111", a_i_rdata); end
   endtask

   task automatic test_write_read();
      int lat, ns; bit ok;
      access_a(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, ns, ok);
      n_vec++; if (lat !== 5 || ns !== 4 || ok !== 1'b1) begin
         n_fail++; $display("FAIL write_access: got lat=%0d strobes=%0d bus_ok=%0d, expected 5/4/1", lat, ns, ok); end
      n_vec++; if (a_d_rdata !== 32'h0) begin
         n_fail++; $display("FAIL write_keeps_rdata: got %h, expected 00000000", a_d_rdata); end
      tick();
      access_a(1'b1, 1'b0, 32'h10, 32'h0, lat, ns, ok);
      n_vec++; if (lat !== 5 || ns !== 4 || ok !== 1'b1) begin
         n_fail++; $display("FAIL read_back_access: got lat=%0d strobes=%0d bus_ok=%0d, expected 5/4/1", lat, ns, ok); end
      n_vec++; if (a_d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL read_back_data: got %h, expected deadbeef", a_d_rdata); end
   endtask

   task automatic test_tie();
      int td = -1, ti = -1;
      pulse_reset();
      a_i_addr = 32'h0; a_d_addr = 32'h4; a_d_we = 1'b0;
      a_i_req = 1'b1; a_d_req = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (a_d_ack === 1'b1) begin td = c; a_d_req = 1'b0; end
         if (a_i_ack === 1'b1) begin ti = c; a_i_req = 1'b0; end
      end
      a_i_req = 1'b0; a_d_req = 1'b0;
      n_vec++; if (td !== 5 || ti !== 10) begin
         n_fail++; $display("FAIL tie_order: got d_ack@%0d i_ack@%0d, expected 5 and 10", td, ti); end
      n_vec++; if (a_i_rdata !== 32'hC0DE_0000 || a_d_rdata !== 32'hC0DE_0001) begin
         n_fail++; $display("FAIL tie_data: got i=%h d=%h, expected c0de0000/c0de0001", a_i_rdata, a_d_rdata); end
   endtask

   task automatic test_contention();
      int n = 0, both = 0;
      int t_ack [8];
      bit is_d [8];
      pulse_reset();
      a_i_addr = 32'h0; a_d_addr = 32'h4; a_d_we = 1'b0;
      a_i_req = 1'b1; a_d_req = 1'b1;
      for (int c = 1; c <= 60 && n < 8; c++) begin
         tick();
         if (a_mem_read && a_mem_write) both++;
         if (a_i_ack && a_d_ack) both++;
         if (a_d_ack === 1'b1) begin is_d[n] = 1'b1; t_ack[n] = c; n++; end
         else if (a_i_ack === 1'b1) begin is_d[n] = 1'b0; t_ack[n] = c; n++; end
      end
      a_i_req = 1'b0; a_d_req = 1'b0;
      n_vec++; if (n !== 8 || both !== 0) begin
         n_fail++; $display("FAIL contention_count: got acks=%0d overlaps=%0d, expected 8/0", n, both); end
      for (int k = 0; k < n; k++) begin
         n_vec++; if (is_d[k] !== (k % 2 == 0) || t_ack[k] !== 5 * (k + 1)) begin
            n_fail++; $display("FAIL contention_ack%0d: got port_d=%0d at %0d, expected port_d=%0d at %0d", k, is_d[k], t_ack[k], (k % 2 == 0), 5 * (k + 1)); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, ns, stray = 0; bit ok;
      a_d_we = 1'b0; a_d_addr = 32'h10; a_d_req = 1'b1;
      tick();              // granted: count loaded with 3
      tick();              // count now 2
      reset = 1'b1; a_d_req = 1'b0;
      tick();
      n_vec++; if ({a_i_ack, a_d_ack, a_mem_read, a_mem_write} !== 4'b0) begin
         n_fail++; $display("FAIL midreset_strobes: got %b, expected 0000", {a_i_ack, a_d_ack, a_mem_read, a_mem_write}); end
      n_vec++; if ({a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin
         n_fail++; $display("FAIL midreset_data: got %h, expected 0", {a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata}); end
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (a_d_ack === 1'b1 || a_mem_read === 1'b1) stray++;
      end
      n_vec++; if (stray !== 0) begin
         n_fail++; $display("FAIL midreset_dropped: got %0d stray cycles, expected 0", stray); end
      access_a(1'b1, 1'b0, 32'h10, 32'h0, lat, ns, ok);
      n_vec++; if (lat !== 5 || ns !== 4 || ok !== 1'b1 || a_d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL midreset_reissue: got lat=%0d strobes=%0d ok=%0d data=%h, expected 5/4/1/deadbeef", lat, ns, ok, a_d_rdata); end
   endtask

   task automatic test_latency1();
      int n = 0, bad = 0;
      int t_ack [6];
      bit is_d [6];
      pulse_reset();
      b_i_addr = 32'h08; b_d_addr = 32'h0C; b_d_we = 1'b0;
      b_i_req = 1'b1; b_d_req = 1'b1;
      for (int c = 1; c <= 20 && n < 6; c++) begin
         tick();
         // Strobe in odd cycles (grant edges), ack in even cycles.
         if (b_mem_read !== (c % 2 == 1) || b_mem_write !== 1'b0) bad++;
         if (b_d_ack === 1'b1) begin is_d[n] = 1'b1; t_ack[n] = c; n++; end
         else if (b_i_ack === 1'b1) begin is_d[n] = 1'b0; t_ack[n] = c; n++; end
      end
      b_i_req = 1'b0; b_d_req = 1'b0;
      n_vec++; if (n !== 6 || bad !== 0) begin
         n_fail++; $display("FAIL lat1_strobes: got acks=%0d bad_cycles=%0d, expected 6/0", n, bad); end
      for (int k = 0; k < n; k++) begin
         n_vec++; if (is_d[k] !== (k % 2 == 0) || t_ack[k] !== 2 * (k + 1)) begin
            n_fail++; $display("FAIL lat1_ack%0d: got port_d=%0d at %0d, expected port_d=%0d at %0d", k, is_d[k], t_ack[k], (k % 2 == 0), 2 * (k + 1)); end
      end
      n_vec++; if (b_i_rdata !== 32'h1111_1111 || b_d_rdata !== 32'hC0DE_0003) begin
         n_fail++; $display("FAIL lat1_data: got i=%h d=%h, expected 11111111/c0de0003", b_i_rdata, b_d_rdata); end
   endtask

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
      b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
      #1;
      tick();
      tick();
      mem_init = 1'b0;
      test_reset();
      test_lone_read();
      test_write_read();
      test_tie();
      test_contention();
      test_reset_mid();
      test_latency1();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
